// File: rtl/encoder83_sync.sv
// Synchronous 8-to-3 event encoder: rising edges on F[7:0] are queued in a
// pending register and delivered one code per clock over a valid/ready handshake.
module encoder83_sync #(
  parameter int unsigned LOW_WINS = 0,
  parameter int unsigned OVF_EN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] F,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] r_state;
  logic [7:0] r_f_d;
  logic [7:0] r_pend;
  logic [2:0] r_code;
  logic       r_ovf;

  logic [7:0] w_evt;
  logic       w_any;
  logic [2:0] w_sel;
  logic       w_load;
  logic [7:0] w_clr;
  logic [7:0] w_pend_nxt;
  logic       w_ovf_set;

  assign w_evt = F & ~r_f_d;
  assign w_any = |r_pend;

  // Priority pick: the last matching index in scan order wins.
  always_comb begin
    w_sel = '0;
    if (LOW_WINS != 0) begin
      for (int unsigned i = 8; i > 0; i--) begin
        if (r_pend[i-1]) w_sel = 3'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (r_pend[i]) w_sel = 3'(i);
      end
    end
  end

  assign w_load = w_any && ((r_state == IDLE) || ready);
  assign w_clr  = w_load ? (8'b0000_0001 << w_sel) : '0;

  // A fresh event re-arms a bit even on the edge its previous occurrence is consumed.
  assign w_pend_nxt = (r_pend & ~w_clr) | w_evt;
  assign w_ovf_set  = |(w_evt & r_pend & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_f_d   <= '1;
      r_pend  <= '0;
      r_code  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_f_d  <= F;
      r_pend <= w_pend_nxt;
      if (w_load) begin
        r_code  <= w_sel;
        r_state <= HOLD;
      end else if (r_state == HOLD && ready) begin
        r_state <= IDLE;
      end
      if (OVF_EN == 0) r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign A     = r_code[2];
  assign B     = r_code[1];
  assign C     = r_code[0];
  assign valid = (r_state == HOLD);
  assign busy  = |r_pend;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_encoder83_sync.sv
// Directed bench for encoder83_sync: default instance plus a LOW_WINS=1, OVF_EN=0 instance.
module tb_encoder83_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] F;
  logic       ready;
  logic       ovf_clr;

  logic A, B, C, valid, busy, ovf;
  logic lA, lB, lC, lvalid, lbusy, lovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder83_sync u_dut (
    .clk(clk), .rst_n(rst_n), .F(F), .A(A), .B(B), .C(C), .valid(valid),
    .ready(ready), .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  encoder83_sync #(.LOW_WINS(1), .OVF_EN(0)) u_dut_lw (
    .clk(clk), .rst_n(rst_n), .F(F), .A(lA), .B(lB), .C(lC), .valid(lvalid),
    .ready(ready), .busy(lbusy), .ovf(lovf), .ovf_clr(ovf_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; F = 8'h00; ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    total++;
    if ({valid, A, B, C, busy, ovf} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", {valid, A, B, C, busy, ovf}, 6'b0);
    end
    total++;
    if ({lvalid, lA, lB, lC, lbusy, lovf} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs_lw got=%b exp=%b", {lvalid, lA, lB, lC, lbusy, lovf}, 6'b0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    F = 8'h00; ready = 1'b1;
    tick();
    F = 8'h20;
    tick();
    total++;
    if ({valid, busy} !== 2'b01) begin
      bad++; $display("FAIL single_pending got=%b exp=%b", {valid, busy}, 2'b01);
    end
    tick();
    total++;
    if ({valid, A, B, C, busy} !== 5'b1_101_0) begin
      bad++; $display("FAIL single_code got=%b exp=%b", {valid, A, B, C, busy}, 5'b1_101_0);
    end
    tick();
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL single_idle got=%b exp=%b", valid, 1'b0);
    end
    F = 8'h00;
    tick();
  endtask

  task automatic test_simultaneous;
    logic [2:0] exp_h[3];
    logic [2:0] exp_l[3];
    exp_h[0] = 3'd7; exp_h[1] = 3'd4; exp_h[2] = 3'd0;
    exp_l[0] = 3'd0; exp_l[1] = 3'd4; exp_l[2] = 3'd7;
    F = 8'h00; ready = 1'b1;
    tick();
    F = 8'h91;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({valid, A, B, C} !== {1'b1, exp_h[i]}) begin
        bad++; $display("FAIL simul_high[%0d] got=%b exp=%b", i, {valid, A, B, C}, {1'b1, exp_h[i]});
      end
      total++;
      if ({lvalid, lA, lB, lC} !== {1'b1, exp_l[i]}) begin
        bad++; $display("FAIL simul_low[%0d] got=%b exp=%b", i, {lvalid, lA, lB, lC}, {1'b1, exp_l[i]});
      end
    end
    tick();
    total++;
    if ({valid, lvalid, busy, lbusy} !== 4'b0) begin
      bad++; $display("FAIL simul_drain got=%b exp=%b", {valid, lvalid, busy, lbusy}, 4'b0);
    end
    F = 8'h00;
    tick();
  endtask

  task automatic test_backpressure;
    ready = 1'b0; F = 8'h08;
    tick();
    F = 8'h00;
    tick();
    total++;
    if ({valid, A, B, C} !== 4'b1_011) begin
      bad++; $display("FAIL bp_first got=%b exp=%b", {valid, A, B, C}, 4'b1_011);
    end
    F = 8'h40;
    tick();
    F = 8'h00;
    tick();
    total++;
    if ({valid, A, B, C, busy} !== 5'b1_011_1) begin
      bad++; $display("FAIL bp_stable got=%b exp=%b", {valid, A, B, C, busy}, 5'b1_011_1);
    end
    ready = 1'b1;
    tick();
    total++;
    if ({valid, A, B, C, busy} !== 5'b1_110_0) begin
      bad++; $display("FAIL bp_second got=%b exp=%b", {valid, A, B, C, busy}, 5'b1_110_0);
    end
    tick();
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL bp_idle got=%b exp=%b", valid, 1'b0);
    end
  endtask

  task automatic test_overflow;
    int n2;
    ready = 1'b0; F = 8'h02;
    tick();
    F = 8'h00;
    tick();
    total++;
    if ({valid, A, B, C} !== 4'b1_001) begin
      bad++; $display("FAIL ovf_hold1 got=%b exp=%b", {valid, A, B, C}, 4'b1_001);
    end
    F = 8'h04; tick();
    F = 8'h00; tick();
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_first_pulse got=%b exp=%b", ovf, 1'b0);
    end
    F = 8'h04; tick();
    F = 8'h00;
    total++;
    if ({ovf, lovf} !== 2'b10) begin
      bad++; $display("FAIL ovf_set got=%b exp=%b", {ovf, lovf}, 2'b10);
    end
    ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b exp=%b", ovf, 1'b0);
    end
    ready = 1'b1;
    n2 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid && {A, B, C} == 3'd2) n2++;
    end
    total++;
    if (n2 !== 1) begin
      bad++; $display("FAIL ovf_code2_count got=%0d exp=%0d", n2, 1);
    end
  endtask

  task automatic test_ovf_set_wins;
    ready = 1'b0; F = 8'h01; tick();
    F = 8'h00; tick();
    F = 8'h02; tick();
    F = 8'h00; tick();
    F = 8'h02; ovf_clr = 1'b1; tick();
    F = 8'h00; ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_set_wins got=%b exp=%b", ovf, 1'b1);
    end
    ready = 1'b1; tick(); tick();
    ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_same_code;
    ready = 1'b0; F = 8'h10; tick();
    F = 8'h00; tick();
    F = 8'h10; tick();
    F = 8'h00;
    total++;
    if ({valid, A, B, C, busy, ovf} !== 6'b1_100_1_0) begin
      bad++; $display("FAIL same_code_pend got=%b exp=%b", {valid, A, B, C, busy, ovf}, 6'b1_100_1_0);
    end
    ready = 1'b1; tick();
    total++;
    if ({valid, A, B, C, busy} !== 5'b1_100_0) begin
      bad++; $display("FAIL same_code_redeliver got=%b exp=%b", {valid, A, B, C, busy}, 5'b1_100_0);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    ready = 1'b0; F = 8'h01; tick();
    F = 8'h00; tick();
    F = 8'h08; tick();
    F = 8'h00; tick();
    ready = 1'b1; F = 8'h08; tick();
    F = 8'h00;
    total++;
    if ({valid, A, B, C, busy, ovf} !== 6'b1_011_1_0) begin
      bad++; $display("FAIL b2b_reload got=%b exp=%b", {valid, A, B, C, busy, ovf}, 6'b1_011_1_0);
    end
    tick();
    total++;
    if ({valid, A, B, C, busy} !== 5'b1_011_0) begin
      bad++; $display("FAIL b2b_second got=%b exp=%b", {valid, A, B, C, busy}, 5'b1_011_0);
    end
    tick();
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%b exp=%b", valid, 1'b0);
    end
  endtask

  task automatic test_reset_level;
    ready = 1'b1; rst_n = 1'b0; F = 8'hFF;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    total++;
    if ({valid, busy} !== 2'b00) begin
      bad++; $display("FAIL level_no_event got=%b exp=%b", {valid, busy}, 2'b00);
    end
    F = 8'h00; tick();
    total++;
    if ({valid, busy} !== 2'b00) begin
      bad++; $display("FAIL level_fall got=%b exp=%b", {valid, busy}, 2'b00);
    end
    F = 8'h01; tick(); tick();
    total++;
    if ({valid, A, B, C} !== 4'b1_000) begin
      bad++; $display("FAIL level_code0 got=%b exp=%b", {valid, A, B, C}, 4'b1_000);
    end
    tick();
    total++;
    if ({valid, busy} !== 2'b00) begin
      bad++; $display("FAIL level_only_one got=%b exp=%b", {valid, busy}, 2'b00);
    end
    F = 8'h00; tick();
  endtask

  task automatic test_reset_mid;
    int nv;
    ready = 1'b0; F = 8'h01; tick();
    F = 8'h00; tick();
    F = 8'h0C; tick();
    F = 8'h00;
    total++;
    if ({valid, busy} !== 2'b11) begin
      bad++; $display("FAIL mid_setup got=%b exp=%b", {valid, busy}, 2'b11);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({valid, busy, A, B, C} !== 5'b0) begin
      bad++; $display("FAIL mid_async_clear got=%b exp=%b", {valid, busy, A, B, C}, 5'b0);
    end
    tick();
    rst_n = 1'b1; ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid || busy) nv++;
    end
    total++;
    if (nv !== 0) begin
      bad++; $display("FAIL mid_no_codes got=%0d exp=%0d", nv, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_ovf_set_wins();
    test_same_code();
    test_back_to_back();
    test_reset_level();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
